// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared PHT counter types and saturating-counter step function
package branch_pkg;

  typedef enum logic [1:0] {
    STRONG_UNTAKEN = 2'b00,
    WEAK_UNTAKEN   = 2'b01,
    WEAK_TAKEN     = 2'b10,
    STRONG_TAKEN   = 2'b11
  } pht_state_t;

  localparam pht_state_t PHT_RESET_STATE = WEAK_UNTAKEN;

  // Saturating step: taken moves toward STRONG_TAKEN, not-taken toward STRONG_UNTAKEN.
  function automatic pht_state_t pht_next(input pht_state_t s, input logic taken);
    pht_state_t n;
    n = s;
    case (s)
      STRONG_UNTAKEN: n = taken ? WEAK_UNTAKEN : STRONG_UNTAKEN;
      WEAK_UNTAKEN:   n = taken ? WEAK_TAKEN   : STRONG_UNTAKEN;
      WEAK_TAKEN:     n = taken ? STRONG_TAKEN : WEAK_UNTAKEN;
      STRONG_TAKEN:   n = taken ? STRONG_TAKEN : WEAK_TAKEN;
      default:        n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - untagged target array, combinational read, synchronous write/reset
module branch_target_buffer #(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [IDX_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [IDX_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int ENTRIES = 1 << IDX_WIDTH;

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // No bypass: a same-cycle write is seen only after the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage 2-bit PHT + BTB predictor; GSHARE_EN adds global history hashing
module branch_predictor
  import branch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     PCF,
  input  logic [WIDTH-1:0]     PCE,
  input  logic [WIDTH-1:0]     PCTargetE,
  input  logic                 BranchOpEb0,
  input  logic                 PCSrcResE,
  input  logic                 StallE,
  input  logic [IDX_WIDTH-1:0] PredIndexE,
  output logic                 PCSrcPredF,
  output logic [WIDTH-1:0]     PredPCTargetF,
  output logic [IDX_WIDTH-1:0] PredIndexF
);

  localparam int ENTRIES = 1 << IDX_WIDTH;

  pht_state_t       pht [ENTRIES];
  logic             update;
  logic [1:0]       cur_state;
  logic             unused_ok;

  assign update = BranchOpEb0 && !StallE;

`ifdef GSHARE_EN
  logic [IDX_WIDTH-1:0] ghr;

  // History advances only on resolved branches, so it never needs repair.
  always_ff @(posedge clk) begin
    if (reset) ghr <= '0;
    else if (update) ghr <= {ghr[IDX_WIDTH-2:0], PCSrcResE};
  end

  assign PredIndexF = PCF[IDX_WIDTH+1:2] ^ ghr;
`else
  assign PredIndexF = PCF[IDX_WIDTH+1:2];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= PHT_RESET_STATE;
    end else if (update) begin
      pht[PredIndexE] <= pht_next(pht[PredIndexE], PCSrcResE);
    end
  end

  assign cur_state  = pht[PredIndexF];
  assign PCSrcPredF = cur_state[1];

  branch_target_buffer #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_btb (
    .clk   (clk),
    .reset (reset),
    .we    (update && PCSrcResE),
    .waddr (PredIndexE),
    .wdata (PCTargetE),
    .raddr (PredIndexF),
    .rdata (PredPCTargetF)
  );

  // PCE and the untranslated PC bits are not needed: indexing comes from PredIndexE.
  assign unused_ok = ^{PCE, PCF[WIDTH-1:IDX_WIDTH+2], PCF[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PCE, PCTargetE;
  logic        BranchOpEb0, PCSrcResE, StallE;
  logic [5:0]  PredIndexE;
  logic        PCSrcPredF;
  logic [31:0] PredPCTargetF;
  logic [5:0]  PredIndexF;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .reset         (reset),
    .PCF           (PCF),
    .PCE           (PCE),
    .PCTargetE     (PCTargetE),
    .BranchOpEb0   (BranchOpEb0),
    .PCSrcResE     (PCSrcResE),
    .StallE        (StallE),
    .PredIndexE    (PredIndexE),
    .PCSrcPredF    (PCSrcPredF),
    .PredPCTargetF (PredPCTargetF),
    .PredIndexF    (PredIndexF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic ep, input logic [31:0] et);
    PCF = pc;
    #1;
    chk({tag, "_pred"}, {31'd0, PCSrcPredF}, {31'd0, ep});
    chk({tag, "_tgt"}, PredPCTargetF, et);
  endtask

  task automatic drive(input logic op, input logic taken, input logic stall,
                       input logic [5:0] idx, input logic [31:0] tgt);
    BranchOpEb0 = op;
    PCSrcResE   = taken;
    StallE      = stall;
    PredIndexE  = idx;
    PCE         = {24'd0, idx, 2'b00};
    PCTargetE   = tgt;
  endtask

  initial begin
    logic [31:0] pc;
    reset = 1'b1;
    PCF = '0;
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state over the whole table
    for (int a = 0; a < 256; a += 4) begin
      pc = a;
      look("rst_sweep", pc, 1'b0, 32'h0);
      chk("rst_idx", {26'd0, PredIndexF}, {26'd0, pc[7:2]});
    end

`ifdef GSHARE_EN
    drive(1'b1, 1'b1, 1'b0, 6'd20, 32'h40);
    tick();
    drive(1'b1, 1'b1, 1'b0, 6'd21, 32'h40);
    tick();
    drive(1'b1, 1'b0, 1'b0, 6'd22, 32'h40);
    tick();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    PCF = 32'h0C;
    #1;
    chk("gshare_idx", {26'd0, PredIndexF}, 32'h05);
`else
    // Taken training at index 3; read-during-write sees the old entry
    drive(1'b1, 1'b1, 1'b0, 6'd3, 32'h100);
    look("t_rdw", 32'h0C, 1'b0, 32'h0);
    tick();
    look("t1", 32'h0C, 1'b1, 32'h100);
    tick();
    look("t2", 32'h0C, 1'b1, 32'h100);
    tick();
    look("t3_sat", 32'h0C, 1'b1, 32'h100);

    // Not-taken walk 11->10->01->00->00, BTB untouched
    drive(1'b1, 1'b0, 1'b0, 6'd3, 32'h200);
    tick();
    look("n1", 32'h0C, 1'b1, 32'h100);
    tick();
    look("n2", 32'h0C, 1'b0, 32'h100);
    tick();
    look("n3", 32'h0C, 1'b0, 32'h100);
    tick();
    look("n4_sat", 32'h0C, 1'b0, 32'h100);
    // From 00 one taken gives 01 (still not predicted), a second gives 10
    drive(1'b1, 1'b1, 1'b0, 6'd3, 32'h100);
    tick();
    look("floor_t1", 32'h0C, 1'b0, 32'h100);
    tick();
    look("floor_t2", 32'h0C, 1'b1, 32'h100);

    // Stall holds state; the update applies once when released
    drive(1'b1, 1'b0, 1'b1, 6'd3, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      look("stall", 32'h0C, 1'b1, 32'h100);
    end
    StallE = 1'b0;
    tick();
    look("unstall", 32'h0C, 1'b0, 32'h100);
    drive(1'b0, 1'b0, 1'b0, 6'd3, 32'h200);
    tick();
    look("bubble_hold", 32'h0C, 1'b0, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 6'd3, 32'h100);
    tick();
    look("once_only", 32'h0C, 1'b1, 32'h100);

    // Reset wins over a same-edge update
    drive(1'b1, 1'b1, 1'b0, 6'd5, 32'h300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    look("rst_coll5", 32'h14, 1'b0, 32'h0);
    look("rst_coll3", 32'h0C, 1'b0, 32'h0);

    // Entry 5 is 01: one taken predicts taken; same-cycle lookup is pre-update
    drive(1'b1, 1'b1, 1'b0, 6'd5, 32'h300);
    look("rdw5", 32'h14, 1'b0, 32'h0);
    tick();
    look("post5", 32'h14, 1'b1, 32'h300);
    look("alias5", 32'h114, 1'b1, 32'h300);

    // Bubble with taken at index 7 changes nothing
    drive(1'b0, 1'b1, 1'b0, 6'd7, 32'h400);
    tick();
    look("bubble7", 32'h1C, 1'b0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
